// File: rtl/uart_rx_dev.sv
// uart_rx_dev: memory-mapped 8N1 serial receiver with a receive FIFO.
// Software sees four word registers (RXDATA, STATUS, CTRL, DIVISOR) selected by addr_i[3:2].
// Bus handshake: a request is a single-cycle pulse on req_i with no stall. Writes commit
// at the edge where req_i & we_i is sampled. Read data appears on data_o the cycle after
// req_i & ~we_i and holds until the next read.
module uart_rx_dev #(
  parameter int          FifoDepth  = 8,
  parameter logic [15:0] DivReset   = 16'd434,
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  rx_i,
  output logic                  irq_o,
  output logic [1:0]            dbg_state
);

  localparam int PW = $clog2(FifoDepth) + 1;  // pointer width, one extra wrap bit
  localparam int AW = PW - 1;                 // memory index width

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

  state_t          state, state_n;
  logic [15:0]     cnt, cnt_n, div, div_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shreg, shreg_n;
  logic            push_req, frame_set;

  logic            rx_meta, rxs, rxs_prev;
  logic            rx_en, irq_en, overrun, frame_err;
  logic [15:0]     divisor;
  logic [7:0]      mem [FifoDepth];
  logic [PW-1:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, count, count_n;
  logic            full, not_empty, rd, wr, pop, push, irq_en_n;
  logic [1:0]      sel;
  logic [DATA_WIDTH-1:0] rdata;
  logic            bits_unused;

  // Only addr_i[3:2] and data_i[15:0] carry meaning.
  assign bits_unused = ^{addr_i[ADDR_WIDTH-1:4], addr_i[1:0], data_i[DATA_WIDTH-1:16]};

  assign dbg_state = state;
  assign sel       = addr_i[3:2];
  assign rd        = req_i & ~we_i;
  assign wr        = req_i & we_i;
  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == PW'(FifoDepth));
  assign not_empty = (count != '0);
  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign pop       = rd & (sel == 2'd0) & not_empty;
  assign push      = push_req & (~full | pop);
  assign wr_ptr_n  = wr_ptr + PW'(push);
  assign rd_ptr_n  = rd_ptr + PW'(pop);
  assign count_n   = wr_ptr_n - rd_ptr_n;
  assign irq_en_n  = (wr && sel == 2'd2) ? data_i[1] : irq_en;

  // Two-flop synchroniser for the asynchronous pin, plus one more stage for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= rx_i;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      div     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      div     <= div_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  // Receiver next state: each bit occupies div+1 cycles, start bit is sampled mid-bit.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    div_n     = div;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    push_req  = 1'b0;
    frame_set = 1'b0;
    if (!rx_en) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rxs_prev && !rxs) begin
            div_n   = divisor;
            cnt_n   = divisor >> 1;
            state_n = START;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (rxs) begin
              state_n = IDLE;
            end else begin
              cnt_n     = div;
              bit_idx_n = '0;
              state_n   = DATA;
            end
          end else begin
            cnt_n = cnt - 16'd1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shreg_n   = {rxs, shreg[7:1]};
            cnt_n     = div;
            bit_idx_n = bit_idx + 3'd1;
            if (bit_idx == 3'd7) state_n = STOP;
          end else begin
            cnt_n = cnt - 16'd1;
          end
        end
        STOP: begin
          if (cnt == '0) begin
            if (rxs) push_req  = 1'b1;
            else     frame_set = 1'b1;
            state_n = IDLE;
          end else begin
            cnt_n = cnt - 16'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // FIFO storage; pointers carry the reset, the array does not need one.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  // Read mux for the register window.
  always_comb begin
    rdata = '0;
    case (sel)
      2'd0: if (not_empty) rdata[7:0] = mem[rd_ptr[AW-1:0]];
      2'd1: begin
        rdata[0]      = not_empty;
        rdata[1]      = overrun;
        rdata[2]      = frame_err;
        rdata[3]      = full;
        rdata[8 +: PW] = count;
      end
      2'd2: rdata[1:0] = {irq_en, rx_en};
      default: rdata[15:0] = divisor;
    endcase
  end

  // Bus registers, FIFO pointers, sticky status and the registered interrupt.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_o    <= '0;
      irq_o     <= 1'b0;
      rx_en     <= 1'b1;
      irq_en    <= 1'b0;
      divisor   <= DivReset;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      if (rd) data_o <= rdata;
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      irq_en <= irq_en_n;
      if (wr) begin
        case (sel)
          2'd1: begin
            if (data_i[1]) overrun   <= 1'b0;
            if (data_i[2]) frame_err <= 1'b0;
          end
          2'd2: rx_en <= data_i[0];
          2'd3: divisor <= (data_i[15:0] < 16'd4) ? 16'd4 : data_i[15:0];
          default: ;
        endcase
      end
      // New events win over a same-cycle clear.
      if (push_req && full && !pop) overrun <= 1'b1;
      if (frame_set) frame_err <= 1'b1;
      irq_o <= irq_en_n & (count_n != '0);
    end
  end

endmodule
